// File: rtl/bus_grant_scheduler_if.sv
// Request/grant bundle between requesters and the bus_grant_scheduler.
// master: scheduler side (drives the grant outputs).
// slave:  requester/memory-port side (drives request and port_done).
interface bus_grant_scheduler_if #(
    parameter int unsigned USER      = 4,
    parameter int unsigned USER_LOG2 = $clog2(USER)
);
    logic [USER-1:0]      request;
    logic                 port_done;
    logic [USER-1:0]      grant;
    logic [USER_LOG2-1:0] grant_user;
    logic                 busy;
    logic                 timeout;

    modport master (
        input  request,
        input  port_done,
        output grant,
        output grant_user,
        output busy,
        output timeout
    );

    modport slave (
        output request,
        output port_done,
        input  grant,
        input  grant_user,
        input  busy,
        input  timeout
    );
endinterface

// File: rtl/bus_grant_scheduler.sv
// Round-robin scheduler granting one memory port to USER requesters.
// IDLE/BUSY FSM with fully registered outputs; 1-cycle request-to-grant latency and
// back-to-back hand-over at release.
// Optional feature: define GRANT_TIMEOUT_EN to abort a grant after TIMEOUT BUSY cycles
// (timeout output pulses for one cycle); without it timeout is tied low.
module bus_grant_scheduler #(
    parameter int unsigned USER      = 4,
    parameter int unsigned USER_LOG2 = $clog2(USER),
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   CLK,
    input  logic                   RST,
    bus_grant_scheduler_if.master  bus
);

    typedef enum logic {StIdle, StBusy} state_t;

    state_t               r_state;
    logic [USER-1:0]      r_grant;
    logic [USER_LOG2-1:0] r_grant_user;
    logic                 r_busy;
    logic [USER_LOG2-1:0] r_last_owner;

    state_t               w_state_nxt;
    logic [USER-1:0]      w_grant_nxt;
    logic [USER_LOG2-1:0] w_grant_user_nxt;
    logic                 w_busy_nxt;
    logic [USER_LOG2-1:0] w_last_owner_nxt;
    logic                 w_timeout_nxt;
    logic                 w_new_grant;

    logic [USER-1:0]      w_others;
    logic                 w_withdraw;
    logic                 w_timeout_hit;
    logic                 w_release;
    logic [USER_LOG2-1:0] w_idle_pick;
    logic [USER_LOG2-1:0] w_next_pick;

    // First set bit of req searching upward from (last+1) mod USER, wrapping.
    function automatic logic [USER_LOG2-1:0] f_pick(input logic [USER-1:0] req,
                                                    input logic [USER_LOG2-1:0] last);
        logic                 found;
        logic [USER_LOG2-1:0] pick;
        int                   idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= int'(USER); i++) begin
            idx = (int'(last) + i) % int'(USER);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = USER_LOG2'(idx);
            end
        end
        return pick;
    endfunction

    assign w_others    = bus.request & ~r_grant;
    assign w_withdraw  = ((bus.request & r_grant) == '0);
    assign w_idle_pick = f_pick(bus.request, r_last_owner);
    // Owner bit is already masked out, so the search never returns the releasing owner.
    assign w_next_pick = f_pick(w_others, r_grant_user);
    assign w_release   = bus.port_done | w_withdraw | w_timeout_hit;

`ifdef GRANT_TIMEOUT_EN
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic        r_timeout;

    // port_done in the terminal cycle wins: normal completion, no abort.
    assign w_timeout_hit = (r_state == StBusy) && (r_count == TIMEOUT[15:0]) && !bus.port_done;

    // BUSY cycle counter: 1 in the first cycle of every grant, 0 while idle.
    always_comb begin
        w_count_nxt = '0;
        if (w_busy_nxt) begin
            w_count_nxt = w_new_grant ? 16'd1 : r_count + 16'd1;
        end
    end

    // Counter and abort pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.timeout = r_timeout;
`else
    logic w_unused_timeout_cfg;

    assign w_timeout_hit        = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT == 0) ^ w_timeout_nxt;
    assign bus.timeout          = 1'b0;
`endif

    // Next-state and next-output decode for the IDLE/BUSY FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_user_nxt = r_grant_user;
        w_busy_nxt       = r_busy;
        w_last_owner_nxt = r_last_owner;
        w_timeout_nxt    = 1'b0;
        w_new_grant      = 1'b0;
        unique case (r_state)
            StIdle: begin
                // port_done is ignored here.
                if (|bus.request) begin
                    w_state_nxt      = StBusy;
                    w_grant_nxt      = USER'(1) << w_idle_pick;
                    w_grant_user_nxt = w_idle_pick;
                    w_busy_nxt       = 1'b1;
                    w_new_grant      = 1'b1;
                end
            end
            StBusy: begin
                if (w_release) begin
                    w_last_owner_nxt = r_grant_user;
                    w_timeout_nxt    = w_timeout_hit;
                    if (|w_others) begin
                        // Hand over without an idle bubble.
                        w_grant_nxt      = USER'(1) << w_next_pick;
                        w_grant_user_nxt = w_next_pick;
                        w_new_grant      = 1'b1;
                    end else if (bus.port_done && !w_withdraw) begin
                        // Sole requester finishing normally may keep the port.
                        w_new_grant      = 1'b1;
                    end else begin
                        w_state_nxt      = StIdle;
                        w_grant_nxt      = '0;
                        w_grant_user_nxt = '0;
                        w_busy_nxt       = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt      = StIdle;
                w_grant_nxt      = '0;
                w_grant_user_nxt = '0;
                w_busy_nxt       = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops the grant asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_grant_user <= '0;
            r_busy       <= 1'b0;
            r_last_owner <= USER_LOG2'(USER - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_user <= w_grant_user_nxt;
            r_busy       <= w_busy_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    assign bus.grant      = r_grant;
    assign bus.grant_user = r_grant_user;
    assign bus.busy       = r_busy;

endmodule

// File: doc/bus_grant_scheduler.md
BUS_GRANT_SCHEDULER -- requirements
Module: bus_grant_scheduler

Interface
REQ-001 SHALL have parameter USER, default 4: number of requesters sharing one memory port (2..16).
REQ-002 SHALL have parameter USER_LOG2, default $clog2(USER): width of the owner index.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles per grant when GRANT_TIMEOUT_EN is defined (1..65535).
REQ-004 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-005 SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port request, input, USER: per-requester request level, held until port_done.
REQ-007 SHALL have port port_done, input, 1: memory port reports completion of the current owner's transaction.
REQ-008 SHALL have port grant, output, USER: one-hot grant, all-zero when idle.
REQ-009 SHALL have port grant_user, output, USER_LOG2: index of current owner, 0 when idle.
REQ-010 SHALL have port busy, output, 1: high while a grant is held.
REQ-011 SHALL have port timeout, output, 1: single-cycle pulse when a grant is aborted (tied 0 without the macro).

Function
REQ-012 SHALL implement two states, IDLE and BUSY; all outputs registered.
REQ-013 IDLE: if request != 0, SHALL select a winner and enter BUSY next cycle with grant, grant_user and busy valid in that cycle (1-cycle request-to-grant latency).
REQ-014 Winner SHALL be the first set request bit searching upward from (last_owner+1) mod USER, wrapping; last_owner resets to USER-1, so index 0 wins first.
REQ-015 BUSY: grant SHALL stay constant regardless of other request changes until release.
REQ-016 Release SHALL occur on port_done=1, or on request[owner]=0 (requester withdrawal), or on timeout; last_owner <= owner at release.
REQ-017 At release, if any request bit other than the owner's is set, SHALL grant the next winner (search from owner+1) in the following cycle with no idle bubble; else return to IDLE with grant=0, busy=0.
REQ-018 At release, the releasing owner SHALL NOT be re-granted in the next cycle even if its request is still set, unless it is the only requester and released by port_done.
REQ-019 port_done in IDLE SHALL be ignored.
REQ-020 Grant SHALL never be all-ones-multiple: at most one grant bit high in any cycle.

Reset
REQ-021 While RST=1: state=IDLE, grant=0, grant_user=0, busy=0, timeout=0, last_owner=USER-1, timeout counter=0.
REQ-022 RST asserted mid-BUSY SHALL drop grant immediately (asynchronously); first grant after release follows REQ-013/REQ-014.

Configuration
REQ-023 Macro GRANT_TIMEOUT_EN: when defined, SHALL count BUSY cycles per grant from 1; if count reaches TIMEOUT without port_done, SHALL release (REQ-016/017) and pulse timeout for exactly one cycle, coincident with the first cycle after release.
REQ-024 Without GRANT_TIMEOUT_EN: no counter logic, timeout tied 0, grant held indefinitely until port_done or withdrawal.
REQ-025 port_done in the same cycle the count reaches TIMEOUT SHALL be treated as normal completion, no timeout pulse.

Verification
REQ-026 Reset then request=4'b0101 -> cycle+1 grant=4'b0001, grant_user=0, busy=1; port_done -> next cycle grant=4'b0100, grant_user=2.
REQ-027 request=4'b1111 held, port_done every 2nd cycle -> grants rotate 0,1,2,3,0 each held 2 cycles, no bubble.
REQ-028 Owner 3 granted, request=4'b1001, port_done -> next grant=4'b0001 (wrap-around), last_owner=3.
REQ-029 Owner 1 granted, request drops to 4'b0000 without port_done -> next cycle grant=0, busy=0, IDLE.
REQ-030 GRANT_TIMEOUT_EN, TIMEOUT=4, request=4'b0011, no port_done -> owner 0 busy 4 cycles, then grant=4'b0010 with timeout=1 for one cycle.
REQ-031 RST pulsed while grant=4'b0100 -> grant=0 immediately; after RST low with request=4'b0100 -> grant=4'b0100 one cycle later.
